// File: rtl/latch_bank_wr_arb.sv
// ---------------------------------------------------------------------------
// latch_bank_wr_arb
//   Round-robin arbitrated write/clear sequencer for a bank of DEPTH x DW
//   transparent latch rows. Each access runs SETUP -> OPEN -> HOLD so that
//   a row enable is never open while the shared data bus moves, and at most
//   one row is open at any time.
//
// Ports
//   CLK        rising-edge clock
//   RN         asynchronous active-low reset (clears the whole bank)
//   req_valid  per-requester request, held until req_ack
//   req_clr    per-requester: 1 = clear row, 0 = write row
//   req_addr   packed row addresses, requester i at [i*AW +: AW]
//   req_data   packed write data, requester i at [i*DW +: DW]
//   req_ack    one-cycle completion pulse to the granted requester
//   req_err    one-cycle pulse with req_ack when address >= DEPTH
//   lat_D      shared data bus to all latch rows
//   lat_E      one-hot row enable, zero when idle
//   lat_RN     per-row active-low clear
//   busy       high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module latch_bank_wr_arb #(
  parameter int NREQ     = 2,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int DW       = 8,
  parameter int OPEN_CYC = 1
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_clr,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_err,
  output logic [DW-1:0]        lat_D,
  output logic [DEPTH-1:0]     lat_E,
  output logic [DEPTH-1:0]     lat_RN,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(OPEN_CYC + 1);
  // One extra bit so DEPTH == 2**AW is representable.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [IW-1:0]       win_r;
  logic                clr_r;
  logic [AW-1:0]       addr_r;
  logic [DW-1:0]       data_r;
  logic [IW-1:0]       ptr_r, ptr_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic                capture_s;

  logic                grant_valid_s;
  logic [IW-1:0]       grant_idx_s;
  logic [IW-1:0]       cand_s;
  logic                sel_clr_s;
  logic [AW-1:0]       sel_addr_s;
  logic [DW-1:0]       sel_data_s;

  logic                in_range_s;
  logic [DEPTH-1:0]    row_sel_s;
  logic [NREQ-1:0]     win_hot_s;

  logic [DW-1:0]       lat_d_r, lat_d_s;
  logic [DEPTH-1:0]    lat_e_r, lat_e_s;
  logic [DEPTH-1:0]    lat_rn_r, lat_rn_s;
  logic [NREQ-1:0]     ack_r, ack_s;
  logic [NREQ-1:0]     err_r, err_s;
  logic                busy_r, busy_s;

  assign lat_D   = lat_d_r;
  assign lat_E   = lat_e_r;
  assign lat_RN  = lat_rn_r;
  assign req_ack = ack_r;
  assign req_err = err_r;
  assign busy    = busy_r;

  // Round-robin pick: scanning downward lets the candidate closest to ptr_r win last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s = IW'((int'(ptr_r) + k) % NREQ);
      if (req_valid[cand_s]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Mux the winning requester's fields.
  always_comb begin
    sel_clr_s  = 1'b0;
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_s == IW'(i)) begin
        sel_clr_s  = req_clr[i];
        sel_addr_s = req_addr[i*AW +: AW];
        sel_data_s = req_data[i*DW +: DW];
      end else begin
        sel_clr_s  = sel_clr_s;
      end
    end
  end

  // Row decode of the captured address and one-hot of the captured winner.
  always_comb begin
    row_sel_s  = '0;
    win_hot_s  = '0;
    in_range_s = ({1'b0, addr_r} < DEPTH_W);
    for (int r = 0; r < DEPTH; r++) begin
      row_sel_s[r] = in_range_s && (addr_r == AW'(r));
    end
    for (int i = 0; i < NREQ; i++) begin
      win_hot_s[i] = (win_r == IW'(i));
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    ptr_s     = ptr_r;
    capture_s = 1'b0;
    lat_d_s   = lat_d_r;
    lat_e_s   = '0;
    lat_rn_s  = '1;
    ack_s     = '0;
    err_s     = '0;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          capture_s = 1'b1;
          state_s   = SETUP;
          // A clear leaves the data bus where it was.
          lat_d_s   = sel_clr_s ? lat_d_r : sel_data_s;
        end else begin
          state_s   = IDLE;
        end
      end
      SETUP: begin
        state_s  = OPEN;
        cnt_s    = '0;
        lat_e_s  = clr_r ? '0 : row_sel_s;
        lat_rn_s = clr_r ? ~row_sel_s : '1;
      end
      OPEN: begin
        if (cnt_r == CW'(OPEN_CYC - 1)) begin
          state_s = HOLD;
          ack_s   = win_hot_s;
          err_s   = in_range_s ? '0 : win_hot_s;
          ptr_s   = (win_r == IW'(NREQ - 1)) ? '0 : win_r + IW'(1);
        end else begin
          cnt_s    = cnt_r + CW'(1);
          lat_e_s  = lat_e_r;
          lat_rn_s = lat_rn_r;
        end
      end
      HOLD: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, capture and output registers; reset clears the whole bank.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      ptr_r    <= '0;
      win_r    <= '0;
      clr_r    <= 1'b0;
      addr_r   <= '0;
      data_r   <= '0;
      lat_d_r  <= '0;
      lat_e_r  <= '0;
      lat_rn_r <= '0;
      ack_r    <= '0;
      err_r    <= '0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      ptr_r    <= ptr_s;
      lat_d_r  <= lat_d_s;
      lat_e_r  <= lat_e_s;
      lat_rn_r <= lat_rn_s;
      ack_r    <= ack_s;
      err_r    <= err_s;
      busy_r   <= busy_s;
      if (capture_s) begin
        win_r  <= grant_idx_s;
        clr_r  <= sel_clr_s;
        addr_r <= sel_addr_s;
        data_r <= sel_data_s;
      end
    end
  end

endmodule
